// File: rtl/mem_arbiter.sv
// Two-port burst arbiter: I-cache (port 0) and D-cache (port 1) share one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 1 has fixed priority.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 22,
  parameter int BURST_LEN     = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Req0_Valid,
  input  logic                     i_Req0_Read_Write_n,
  input  logic [ADDRESS_WIDTH-1:0] i_Req0_Address,
  input  logic [DATA_WIDTH-1:0]    i_Req0_Data,
  output logic                     o_Req0_Valid,
  output logic                     o_Req0_Data_Read,
  output logic                     o_Req0_Last,
  output logic [DATA_WIDTH-1:0]    o_Req0_Data,
  input  logic                     i_Req1_Valid,
  input  logic                     i_Req1_Read_Write_n,
  input  logic [ADDRESS_WIDTH-1:0] i_Req1_Address,
  input  logic [DATA_WIDTH-1:0]    i_Req1_Data,
  output logic                     o_Req1_Valid,
  output logic                     o_Req1_Data_Read,
  output logic                     o_Req1_Last,
  output logic [DATA_WIDTH-1:0]    o_Req1_Data,
  output logic                     o_MEM_Valid,
  output logic                     o_MEM_Read_Write_n,
  output logic [ADDRESS_WIDTH-1:0] o_MEM_Address,
  output logic [DATA_WIDTH-1:0]    o_MEM_Data,
  input  logic                     i_MEM_Valid,
  input  logic                     i_MEM_Data_Read,
  input  logic                     i_MEM_Last,
  input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
  output logic [1:0]               o_Grant,
  output logic                     o_Protocol_Error
);

  localparam int CNT_W = ($clog2(BURST_LEN + 1) > 3) ? $clog2(BURST_LEN + 1) : 3;
  localparam logic [CNT_W:0] BURST_LEN_C = (CNT_W + 1)'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             err_q, err_d;
  logic             gnt0, gnt1, win1;
  logic             sel_valid, sel_rw, beat_acc;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
`endif

  assign gnt0    = (state_q == GRANT0);
  assign gnt1    = (state_q == GRANT1);
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    win1 = i_Req1_Valid;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_Req0_Valid && i_Req1_Valid) win1 = ~ptr_q;
`endif
  end

  always_comb begin
    sel_valid          = 1'b0;
    sel_rw             = 1'b0;
    o_MEM_Address      = '0;
    o_MEM_Data         = '0;
    if (gnt0) begin
      sel_valid     = i_Req0_Valid;
      sel_rw        = i_Req0_Read_Write_n;
      o_MEM_Address = i_Req0_Address;
      o_MEM_Data    = i_Req0_Data;
    end else if (gnt1) begin
      sel_valid     = i_Req1_Valid;
      sel_rw        = i_Req1_Read_Write_n;
      o_MEM_Address = i_Req1_Address;
      o_MEM_Data    = i_Req1_Data;
    end
    o_MEM_Valid        = sel_valid;
    o_MEM_Read_Write_n = sel_rw;
    beat_acc           = sel_valid && (sel_rw ? i_MEM_Valid : i_MEM_Data_Read);
  end

  // Strobes are gated by the owner's Valid so an aborting requester never sees Last.
  always_comb begin
    o_Req0_Valid     = gnt0 & i_Req0_Valid & i_MEM_Valid;
    o_Req0_Data_Read = gnt0 & i_Req0_Valid & i_MEM_Data_Read;
    o_Req0_Last      = gnt0 & i_Req0_Valid & i_MEM_Last;
    o_Req1_Valid     = gnt1 & i_Req1_Valid & i_MEM_Valid;
    o_Req1_Data_Read = gnt1 & i_Req1_Valid & i_MEM_Data_Read;
    o_Req1_Last      = gnt1 & i_Req1_Valid & i_MEM_Last;
    o_Req0_Data      = (gnt0 | gnt1) ? i_MEM_Data : '0;
    o_Req1_Data      = (gnt0 | gnt1) ? i_MEM_Data : '0;
    o_Grant          = {gnt1, gnt0};
    o_Protocol_Error = err_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_Req0_Valid || i_Req1_Valid) begin
          state_d = win1 ? GRANT1 : GRANT0;
          cnt_d   = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_d   = win1;
`endif
        end
      end
      GRANT0, GRANT1: begin
        if (!sel_valid) begin
          state_d = IDLE;
        end else if (beat_acc) begin
          if (i_MEM_Last) begin
            state_d = IDLE;
            if (cnt_inc != BURST_LEN_C) err_d = 1'b1;
          end else if (cnt_q != '1) begin
            // Saturating: an overlong burst still mismatches BURST_LEN at Last.
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule
